// File: rtl/core_itlb_lookup_responder.sv
// Fetch-side TLB lookup responder: fully-associative LA32 TLB array with TLBWR/TLBFILL writes and INVTLB invalidation.
// Latency: one cycle from request accept to registered result; one lookup per cycle when the consumer keeps up.
// Backpressure: req_ready_o drops while a result is held unconsumed or while a maintenance op occupies the cycle.
module core_itlb_lookup_responder #(
    parameter int TLB_ENTRIES = 16,
    localparam int IDX_W = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    input  logic [19:0]      req_vppn_i,
    input  logic [9:0]       req_asid_i,
    output logic             req_ready_o,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_found_o,
    output logic [IDX_W-1:0] resp_index_o,
    output logic [19:0]      resp_ppn_o,
    output logic [5:0]       resp_ps_o,
    output logic [1:0]       resp_plv_o,
    output logic [1:0]       resp_mat_o,
    output logic             resp_d_o,
    output logic             resp_v_o,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_index_i,
    input  logic [18:0]      wr_vppn_i,
    input  logic [9:0]       wr_asid_i,
    input  logic [5:0]       wr_ps_i,
    input  logic             wr_e_i,
    input  logic [31:0]      wr_elo0_i,
    input  logic [31:0]      wr_elo1_i,
    input  logic             inv_valid_i,
    input  logic [4:0]       inv_op_i,
    input  logic [9:0]       inv_asid_i,
    input  logic [18:0]      inv_vppn_i
);

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic [5:0]  ps;
        logic        g;
        logic [19:0] ppn0;
        logic [19:0] ppn1;
        logic [1:0]  plv0;
        logic [1:0]  plv1;
        logic [1:0]  mat0;
        logic [1:0]  mat1;
        logic        d0;
        logic        d1;
        logic        v0;
        logic        v1;
    } tlb_entry_t;

    tlb_entry_t tlb_q [TLB_ENTRIES];
    tlb_entry_t wr_entry;
    tlb_entry_t sel;

    logic [TLB_ENTRIES-1:0] hit;
    logic [TLB_ENTRIES-1:0] inv_hit;
    logic                   lk_found;
    logic [IDX_W-1:0]       lk_index;
    logic                   lk_odd;
    logic [19:0]            lk_ppn_raw;
    logic                   accept;

    // ELO reserved bits carry no meaning here.
    logic unused_elo;
    assign unused_elo = ^{wr_elo0_i[31:28], wr_elo0_i[7], wr_elo1_i[31:28], wr_elo1_i[7]};

    assign req_ready_o = !wr_en_i && !inv_valid_i && (!resp_valid_o || resp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    assign wr_entry = '{e: wr_e_i, vppn: wr_vppn_i, asid: wr_asid_i, ps: wr_ps_i,
                        g: wr_elo0_i[6] & wr_elo1_i[6],
                        ppn0: wr_elo0_i[27:8], ppn1: wr_elo1_i[27:8],
                        plv0: wr_elo0_i[3:2], plv1: wr_elo1_i[3:2],
                        mat0: wr_elo0_i[5:4], mat1: wr_elo1_i[5:4],
                        d0: wr_elo0_i[1], d1: wr_elo1_i[1],
                        v0: wr_elo0_i[0], v1: wr_elo1_i[0]};

    // Per-entry lookup match; page sizes other than 4KB/4MB never match.
    always_comb begin
        hit = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            hit[i] = tlb_q[i].e && (tlb_q[i].g || tlb_q[i].asid == req_asid_i) &&
                     ((tlb_q[i].ps == 6'd12) ? (tlb_q[i].vppn == req_vppn_i[19:1]) :
                      (tlb_q[i].ps == 6'd22) ? (tlb_q[i].vppn[18:10] == req_vppn_i[19:11]) : 1'b0);
        end
    end

    // Priority select: scanning downward leaves the lowest matching index.
    always_comb begin
        lk_found = 1'b0;
        lk_index = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                lk_found = 1'b1;
                lk_index = i[IDX_W-1:0];
            end
        end
    end

    assign sel        = tlb_q[lk_index];
    assign lk_odd     = (sel.ps == 6'd12) ? req_vppn_i[0] : req_vppn_i[10];
    assign lk_ppn_raw = lk_odd ? sel.ppn1 : sel.ppn0;

    // INVTLB selection per entry; va match follows each entry's own page size.
    always_comb begin
        inv_hit = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            logic asid_m;
            logic va_m;
            asid_m = (tlb_q[i].asid == inv_asid_i);
            va_m   = (tlb_q[i].ps == 6'd12) ? (tlb_q[i].vppn == inv_vppn_i) :
                     (tlb_q[i].ps == 6'd22) ? (tlb_q[i].vppn[18:10] == inv_vppn_i[18:10]) : 1'b0;
            case (inv_op_i)
                5'd0, 5'd1: inv_hit[i] = 1'b1;
                5'd2:       inv_hit[i] = tlb_q[i].g;
                5'd3:       inv_hit[i] = !tlb_q[i].g;
                5'd4:       inv_hit[i] = !tlb_q[i].g && asid_m;
                5'd5:       inv_hit[i] = !tlb_q[i].g && asid_m && va_m;
                5'd6:       inv_hit[i] = (tlb_q[i].g || asid_m) && va_m;
                default:    inv_hit[i] = 1'b0;
            endcase
        end
    end

    // Array update: invalidate first, then the write so a written entry survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLB_ENTRIES; i++) tlb_q[i] <= '0;
        end else begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                if (inv_valid_i && inv_hit[i]) tlb_q[i].e <= 1'b0;
            end
            if (wr_en_i) tlb_q[wr_index_i] <= wr_entry;
        end
    end

    // Result register: flush wins over a same-cycle accept; data held until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_o <= 1'b0;
            resp_found_o <= 1'b0;
            resp_index_o <= '0;
            resp_ppn_o   <= '0;
            resp_ps_o    <= '0;
            resp_plv_o   <= '0;
            resp_mat_o   <= '0;
            resp_d_o     <= 1'b0;
            resp_v_o     <= 1'b0;
        end else if (flush_i) begin
            resp_valid_o <= 1'b0;
        end else if (accept) begin
            resp_valid_o <= 1'b1;
            resp_found_o <= lk_found;
            resp_index_o <= lk_found ? lk_index : '0;
            resp_ps_o    <= lk_found ? sel.ps : 6'd0;
            resp_plv_o   <= !lk_found ? 2'd0 : (lk_odd ? sel.plv1 : sel.plv0);
            resp_mat_o   <= !lk_found ? 2'd0 : (lk_odd ? sel.mat1 : sel.mat0);
            resp_d_o     <= lk_found && (lk_odd ? sel.d1 : sel.d0);
            resp_v_o     <= lk_found && (lk_odd ? sel.v1 : sel.v0);
            if (!lk_found)
                resp_ppn_o <= '0;
            else if (sel.ps == 6'd22)
                resp_ppn_o <= {lk_ppn_raw[19:10], req_vppn_i[9:0]};
            else
                resp_ppn_o <= lk_ppn_raw;
        end else if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_itlb_lookup_responder.sv
// Directed bench for core_itlb_lookup_responder with an expected-result queue.
// Stimulus pushes the hand-computed result at accept; a negedge monitor compares every shown result.
// Results are popped on the consumer handshake, so held data is checked each cycle it is presented.
module tb_core_itlb_lookup_responder;

    typedef struct packed {
        logic        found;
        logic [3:0]  index;
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [19:0] req_vppn = '0;
    logic [9:0]  req_asid = '0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic        resp_found;
    logic [3:0]  resp_index;
    logic [19:0] resp_ppn;
    logic [5:0]  resp_ps;
    logic [1:0]  resp_plv;
    logic [1:0]  resp_mat;
    logic        resp_d;
    logic        resp_v;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_index = '0;
    logic [18:0] wr_vppn = '0;
    logic [9:0]  wr_asid = '0;
    logic [5:0]  wr_ps = '0;
    logic        wr_e = 1'b0;
    logic [31:0] wr_elo0 = '0;
    logic [31:0] wr_elo1 = '0;
    logic        inv_valid = 1'b0;
    logic [4:0]  inv_op = '0;
    logic [9:0]  inv_asid = '0;
    logic [18:0] inv_vppn = '0;

    int   tests = 0;
    int   fails = 0;
    res_t exp_q[$];
    res_t got;

    core_itlb_lookup_responder #(.TLB_ENTRIES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_vppn_i(req_vppn), .req_asid_i(req_asid), .req_ready_o(req_ready),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_found_o(resp_found),
        .resp_index_o(resp_index), .resp_ppn_o(resp_ppn), .resp_ps_o(resp_ps),
        .resp_plv_o(resp_plv), .resp_mat_o(resp_mat), .resp_d_o(resp_d), .resp_v_o(resp_v),
        .flush_i(flush), .wr_en_i(wr_en), .wr_index_i(wr_index), .wr_vppn_i(wr_vppn),
        .wr_asid_i(wr_asid), .wr_ps_i(wr_ps), .wr_e_i(wr_e), .wr_elo0_i(wr_elo0), .wr_elo1_i(wr_elo1),
        .inv_valid_i(inv_valid), .inv_op_i(inv_op), .inv_asid_i(inv_asid), .inv_vppn_i(inv_vppn)
    );

    always #5 clk = ~clk;

    assign got = '{found: resp_found, index: resp_index, ppn: resp_ppn, ps: resp_ps,
                   plv: resp_plv, mat: resp_mat, d: resp_d, v: resp_v};

    function automatic logic [31:0] mk_elo(input logic [19:0] ppn, input logic g, input logic [1:0] mat,
                                           input logic [1:0] plv, input logic d, input logic v);
        return {4'h0, ppn, 1'b0, g, mat, plv, d, v};
    endfunction

    function automatic res_t mk_res(input logic f, input logic [3:0] idx, input logic [19:0] ppn,
                                    input logic [5:0] ps, input logic [1:0] plv, input logic [1:0] mat,
                                    input logic d, input logic v);
        return '{found: f, index: idx, ppn: ppn, ps: ps, plv: plv, mat: mat, d: d, v: v};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every presented result must equal the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_resp: got %h with nothing expected at %0t", got, $time);
            end else begin
                if (got !== exp_q[0]) begin
                    fails++;
                    $display("FAIL resp_data: got %h expected %h at %0t", got, exp_q[0], $time);
                end
                if (resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Issue one lookup (starts and ends just after a posedge).
    task automatic do_lookup(input logic [19:0] vppn, input logic [9:0] asid, input res_t e);
        int n;
        req_valid = 1'b1; req_vppn = vppn; req_asid = asid;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin n++; @(negedge clk); end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL req_timeout: req_ready stayed 0 for vppn %h", vppn);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic set_wr(input logic [3:0] idx, input logic [18:0] vppn, input logic [9:0] asid,
                          input logic [5:0] ps, input logic [31:0] e0, input logic [31:0] e1);
        wr_en = 1'b1; wr_index = idx; wr_vppn = vppn; wr_asid = asid; wr_ps = ps;
        wr_e = 1'b1; wr_elo0 = e0; wr_elo1 = e1;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [18:0] vppn, input logic [9:0] asid,
                            input logic [5:0] ps, input logic [31:0] e0, input logic [31:0] e1);
        set_wr(idx, vppn, asid, ps, e0, e1);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Invalidate, optionally alongside a write already set up with set_wr.
    task automatic do_inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
        inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
        @(posedge clk); #1;
        inv_valid = 1'b0; wr_en = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin n++; @(posedge clk); #1; end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d results never presented", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // T1: reset state, then a miss on an empty array
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("rst_valid", resp_valid, 1'b0);
        check_bit("rst_found", resp_found, 1'b0);
        check_bit("rst_ppn_zero", |resp_ppn, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("ready_after_rst", req_ready, 1'b1);
        @(posedge clk); #1;
        do_lookup(20'h00400, 10'd0, '0);
        drain();

        // T2: 4KB entry at idx3, odd/even halves and ASID mismatch
        do_write(4'd3, 19'h00200, 10'd5, 6'd12,
                 mk_elo(20'h01234, 1'b0, 2'd0, 2'd3, 1'b1, 1'b1),
                 mk_elo(20'h05678, 1'b0, 2'd1, 2'd0, 1'b0, 1'b1));
        do_lookup(20'h00401, 10'd5, mk_res(1'b1, 4'd3, 20'h05678, 6'd12, 2'd0, 2'd1, 1'b0, 1'b1));
        do_lookup(20'h00400, 10'd5, mk_res(1'b1, 4'd3, 20'h01234, 6'd12, 2'd3, 2'd0, 1'b1, 1'b1));
        do_lookup(20'h00401, 10'd6, '0);
        drain();

        // T3: three back-to-back requests, second result stalled two cycles
        req_valid = 1'b1; req_vppn = 20'h00400; req_asid = 10'd5;
        @(negedge clk);
        check_bit("t3_ready1", req_ready, 1'b1);
        exp_q.push_back(mk_res(1'b1, 4'd3, 20'h01234, 6'd12, 2'd3, 2'd0, 1'b1, 1'b1));
        @(posedge clk); #1;
        req_vppn = 20'h00401;
        @(negedge clk);
        check_bit("t3_ready2", req_ready, 1'b1);
        exp_q.push_back(mk_res(1'b1, 4'd3, 20'h05678, 6'd12, 2'd0, 2'd1, 1'b0, 1'b1));
        @(posedge clk); #1;
        req_vppn = 20'h00401; req_asid = 10'd6; resp_ready = 1'b0;
        @(negedge clk);
        check_bit("t3_stall_a", req_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("t3_stall_b", req_ready, 1'b0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check_bit("t3_ready3", req_ready, 1'b1);
        exp_q.push_back('0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();

        // T4: two global matches, unknown op, inv+write same cycle, selective ops
        do_write(4'd2, 19'h01000, 10'd9, 6'd12,
                 mk_elo(20'h00AAA, 1'b1, 2'd1, 2'd1, 1'b0, 1'b1), mk_elo(20'h0CCCC, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0));
        do_write(4'd7, 19'h01000, 10'd9, 6'd12,
                 mk_elo(20'h00BBB, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1), mk_elo(20'h0DDDD, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0));
        do_lookup(20'h02000, 10'd1, mk_res(1'b1, 4'd2, 20'h00AAA, 6'd12, 2'd1, 2'd1, 1'b0, 1'b1));
        do_inv(5'd7, 10'd0, 19'h0);
        do_lookup(20'h02000, 10'd1, mk_res(1'b1, 4'd2, 20'h00AAA, 6'd12, 2'd1, 2'd1, 1'b0, 1'b1));
        set_wr(4'd7, 19'h01000, 10'd9, 6'd12,
               mk_elo(20'h00BBB, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1), mk_elo(20'h0DDDD, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0));
        do_inv(5'd2, 10'd0, 19'h0);
        do_lookup(20'h02000, 10'd1, mk_res(1'b1, 4'd7, 20'h00BBB, 6'd12, 2'd2, 2'd2, 1'b1, 1'b1));
        do_inv(5'd2, 10'd0, 19'h0);
        do_lookup(20'h02000, 10'd1, '0);
        do_lookup(20'h00401, 10'd5, mk_res(1'b1, 4'd3, 20'h05678, 6'd12, 2'd0, 2'd1, 1'b0, 1'b1));
        do_inv(5'd5, 10'd5, 19'h00200);
        do_lookup(20'h00401, 10'd5, '0);
        drain();

        // T5: 4MB entry, odd and even halves with VA[21:12] substitution
        do_write(4'd5, 19'h00400, 10'd0, 6'd22,
                 mk_elo(20'h11111, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1), mk_elo(20'h40000, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1));
        do_lookup(20'h00E05, 10'd3, mk_res(1'b1, 4'd5, 20'h40205, 6'd22, 2'd2, 2'd1, 1'b1, 1'b1));
        do_lookup(20'h00A05, 10'd3, mk_res(1'b1, 4'd5, 20'h11205, 6'd22, 2'd0, 2'd0, 1'b0, 1'b1));
        drain();

        // Write to the matched entry while its result is held does not disturb that result
        resp_ready = 1'b0;
        do_lookup(20'h00E05, 10'd3, mk_res(1'b1, 4'd5, 20'h40205, 6'd22, 2'd2, 2'd1, 1'b1, 1'b1));
        do_write(4'd5, 19'h00400, 10'd0, 6'd22,
                 mk_elo(20'h11111, 1'b1, 2'd0, 2'd0, 1'b0, 1'b1), mk_elo(20'h7FC00, 1'b1, 2'd3, 2'd1, 1'b0, 1'b1));
        resp_ready = 1'b1;
        drain();

        // T6: write alongside a request stalls it for that cycle only
        set_wr(4'd9, 19'h7FFFF, 10'd1, 6'd12, '0, '0);
        req_valid = 1'b1; req_vppn = 20'h00E05; req_asid = 10'd3;
        @(negedge clk);
        check_bit("wr_stalls_req", req_ready, 1'b0);
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        check_bit("ready_after_wr", req_ready, 1'b1);
        exp_q.push_back(mk_res(1'b1, 4'd5, 20'h7FE05, 6'd22, 2'd1, 2'd3, 1'b0, 1'b1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();

        // T6: flush in the cycle the result appears
        resp_ready = 1'b0;
        req_valid = 1'b1; req_vppn = 20'h00A05; req_asid = 10'd3;
        @(negedge clk);
        exp_q.push_back(mk_res(1'b1, 4'd5, 20'h11205, 6'd22, 2'd0, 2'd0, 1'b0, 1'b1));
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check_bit("flush_valid_rise", resp_valid, 1'b1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check_bit("flush_valid_drop", resp_valid, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        resp_ready = 1'b1;
        do_lookup(20'h00A05, 10'd3, mk_res(1'b1, 4'd5, 20'h11205, 6'd22, 2'd0, 2'd0, 1'b0, 1'b1));
        drain();

        // Reset while a result is pending: result dropped, array emptied
        resp_ready = 1'b0;
        do_lookup(20'h00E05, 10'd3, mk_res(1'b1, 4'd5, 20'h7FE05, 6'd22, 2'd1, 2'd3, 1'b0, 1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("rst_mid_valid", resp_valid, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        resp_ready = 1'b1;
        do_lookup(20'h00E05, 10'd3, '0);
        drain();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
